// File: rtl/shiftreg_pkg.sv
// Shared constants for the serial shift-register transmit path.
// State encoding and default sizing used by controller and core.
package shiftreg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/shiftreg_core.sv
// Parallel-load, shift-left register; MSB is the serial tap.
// Load has priority over shift; neither asserted holds the value.
module shiftreg_core
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pdin,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = pdin;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/shiftreg_tx_ctrl.sv
// Serial transmit controller: accepts a parallel word, shifts it out
// one bit per clock with an enable strobe, then idles for a fixed gap.
module shiftreg_tx_ctrl
    import shiftreg_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int GAP_CYCLES = DEF_GAP
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             sout,
    output logic             sout_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [7:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit NO_GAP = (GAP_CYCLES == 0);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   bit_cnt_q;
    logic [CW-1:0]   bit_cnt_d;
    logic [7:0]      gap_cnt_q;
    logic [7:0]      gap_cnt_d;

    logic             load;
    logic             shift;
    logic             msb;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] din_rev;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        din_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            din_rev[i] = din[WIDTH-1-i];
        end
    end

    assign load_val = lsb_first ? din_rev : din;

    assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    // With no gap the last bit cycle can take the next word directly.
    assign din_ready = clr &&
        ((state_q == ST_IDLE) || (NO_GAP && last_bit));
    assign accept = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    bit_cnt_d = LAST;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    shift     = 1'b1;
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else if (accept) begin
                    load      = 1'b1;
                    bit_cnt_d = LAST;
                end else if (!NO_GAP) begin
                    gap_cnt_d = GAP_LAST;
                    state_d   = ST_GAP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sout_en = (state_q == ST_SHIFT);
        sout    = sout_en && msb;
        busy    = (state_q != ST_IDLE);
        done    = last_bit;
    end

    shiftreg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .shift (shift),
        .pdin  (load_val),
        .msb   (msb)
    );

endmodule
